// File: rtl/ips_pulse_gen_if.sv
// ips_pulse_gen_if: control/status bundle between a test controller and the
// inductive-proximity-sensor emulator. The controller uses the master modport
// and the emulator uses the slave modport.
interface ips_pulse_gen_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] gap_len;
  logic [NUM_W-1:0] num_pulses;
  logic             IPS_detect;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulses_sent;

  modport master (
    output start, stop, pulse_len, gap_len, num_pulses,
    input  IPS_detect, busy, done, pulses_sent
  );

  modport slave (
    input  start, stop, pulse_len, gap_len, num_pulses,
    output IPS_detect, busy, done, pulses_sent
  );

endinterface

// File: rtl/ips_pulse_gen.sv
// ips_pulse_gen: inductive-proximity-sensor emulator. On start it emits a
// burst of num_pulses high pulses of pulse_len cycles separated by gap_len
// low cycles (zero lengths behave as one cycle), then a one-cycle done.
// stop aborts to IDLE at the next edge and keeps the completed-pulse count.
// Optional build macro IPS_GEN_BOUNCE_EN: the first 2*BOUNCE_N cycles of each
// high phase toggle 1,0,1,0,... to mimic contact bounce; gaps stay clean.
module ips_pulse_gen #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NUM_W    = 8,
  parameter int unsigned BOUNCE_N = 3
) (
  input  logic           CLK,
  input  logic           RESET_N,
  ips_pulse_gen_if.slave bus
);

  // Reject degenerate parameterisations at elaboration
  if (CNT_W < 1 || NUM_W < 1 || BOUNCE_N < 1) begin : g_param_chk
    $error("ips_pulse_gen: CNT_W, NUM_W and BOUNCE_N must all be >= 1");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] sent_q, sent_d;
  logic             ips_q, ips_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last_pulse_c;
  logic [NUM_W-1:0] sent_inc_c;

`ifdef IPS_GEN_BOUNCE_EN
  localparam int unsigned BOUNCE_CYC = 2 * BOUNCE_N;
  localparam int unsigned BW         = $clog2(BOUNCE_CYC + 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
`endif

  // Down-counter reload value: a length of L cycles counts L-1 .. 0, 0 acts as 1
  function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] len);
    load_len = (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  // Pulse bookkeeping: is the pulse now ending the last one, saturating increment
  always_comb begin
    last_pulse_c = ({1'b0, sent_q} + (NUM_W+1)'(1)) >= {1'b0, num_q};
    sent_inc_c   = (sent_q == '1) ? sent_q : sent_q + NUM_W'(1);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_len_d = pulse_len_q;
    gap_len_d   = gap_len_q;
    num_d       = num_q;
    sent_d      = sent_q;
    ips_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef IPS_GEN_BOUNCE_EN
    bcnt_d      = bcnt_q;
`endif

    if (bus.stop) begin
      // Abort wins over everything, including a simultaneous start
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            pulse_len_d = bus.pulse_len;
            gap_len_d   = bus.gap_len;
            num_d       = bus.num_pulses;
            sent_d      = '0;
            if (bus.num_pulses == '0) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              state_d = S_HIGH;
              cnt_d   = load_len(bus.pulse_len);
              ips_d   = 1'b1;
              busy_d  = 1'b1;
`ifdef IPS_GEN_BOUNCE_EN
              bcnt_d  = BW'(1);
`endif
            end
          end
        end

        S_HIGH: begin
          busy_d = 1'b1;
          if (cnt_q == '0) begin
            sent_d = sent_inc_c;
            if (last_pulse_c) begin
              state_d = S_FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_LOW;
              cnt_d   = load_len(gap_len_q);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
`ifdef IPS_GEN_BOUNCE_EN
            if (bcnt_q < BW'(BOUNCE_CYC)) begin
              ips_d  = ~bcnt_q[0];
              bcnt_d = bcnt_q + BW'(1);
            end else begin
              ips_d  = 1'b1;
            end
`else
            ips_d = 1'b1;
`endif
          end
        end

        S_LOW: begin
          busy_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = load_len(pulse_len_q);
            ips_d   = 1'b1;
`ifdef IPS_GEN_BOUNCE_EN
            bcnt_d  = BW'(1);
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_FIN: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, timing counter, latched config and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pulse_len_q <= '0;
      gap_len_q   <= '0;
      num_q       <= '0;
      sent_q      <= '0;
      ips_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_len_q <= pulse_len_d;
      gap_len_q   <= gap_len_d;
      num_q       <= num_d;
      sent_q      <= sent_d;
      ips_q       <= ips_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef IPS_GEN_BOUNCE_EN
  // Position within the bounce prefix of the current high phase
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end
`endif

  assign bus.IPS_detect  = ips_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_ips_pulse_gen.sv
// tb_ips_pulse_gen: directed and randomized bursts for ips_pulse_gen, each
// compared cycle by cycle against a waveform built from the burst rules.
module tb_ips_pulse_gen;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NUM_W    = 8;
  localparam int unsigned BOUNCE_N = 3;

  logic CLK = 1'b0;
  logic RESET_N;
  int   total = 0;
  int   bad   = 0;

  int unsigned q_ips[$];
  int unsigned q_ps[$];

  always #5 CLK = ~CLK;

  ips_pulse_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  ips_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W), .BOUNCE_N(BOUNCE_N)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned ips, input int unsigned busy,
                           input int unsigned done, input int unsigned ps);
    check({tag, ".ips"},  32'(bus.IPS_detect),  ips);
    check({tag, ".busy"}, 32'(bus.busy),        busy);
    check({tag, ".done"}, 32'(bus.done),        done);
    check({tag, ".sent"}, 32'(bus.pulses_sent), ps);
  endtask

  // Expected waveform for one burst: detect level and completed count per cycle
  task automatic build(input int p, input int g, input int n);
    int ep;
    int eg;
    int ps;
    ep = (p == 0) ? 1 : p;
    eg = (g == 0) ? 1 : g;
    ps = 0;
    q_ips.delete();
    q_ps.delete();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < ep; j++) begin
        int unsigned v;
        v = 1;
`ifdef IPS_GEN_BOUNCE_EN
        if (j < 2 * BOUNCE_N) v = ((j % 2) == 0) ? 1 : 0;
`endif
        q_ips.push_back(v);
        q_ps.push_back(ps);
      end
      ps++;
      if (k != n - 1) begin
        for (int j = 0; j < eg; j++) begin
          q_ips.push_back(0);
          q_ps.push_back(ps);
        end
      end
    end
  endtask

  // One burst; stop_at >= 0 aborts (with a competing start) during that cycle
  task automatic run_burst(input int p, input int g, input int n, input int stop_at,
                           input string tag);
    build(p, g, n);
    bus.pulse_len  = CNT_W'(p);
    bus.gap_len    = CNT_W'(g);
    bus.num_pulses = NUM_W'(n);
    bus.stop       = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < q_ips.size(); i++) begin
      check_out($sformatf("%s.c%0d", tag, i), q_ips[i], 1, 0, q_ps[i]);
      bus.pulse_len  = CNT_W'($urandom);
      bus.gap_len    = CNT_W'($urandom);
      bus.num_pulses = NUM_W'($urandom);
      bus.start      = 1'($urandom_range(0, 1));
      if (i == stop_at) begin
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check_out({tag, ".abort"}, 0, 0, 0, q_ps[i]);
        for (int k = 0; k < 3; k++) begin
          tick();
          check_out($sformatf("%s.post%0d", tag, k), 0, 0, 0, q_ps[i]);
        end
        return;
      end
      tick();
    end
    bus.start = 1'b0;
    check_out({tag, ".done"}, 0, 0, 1, n);
    tick();
    check_out({tag, ".idle"}, 0, 0, 0, n);
  endtask

  initial begin
    int p;
    int g;
    int n;
    int s;
    RESET_N        = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.pulse_len  = '0;
    bus.gap_len    = '0;
    bus.num_pulses = '0;
    #2 RESET_N = 1'b0;
    #1 check_out("reset", 0, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    check_out("post_reset", 0, 0, 0, 0);

    run_burst(4, 6, 3, -1, "basic");
    run_burst(0, 0, 2, -1, "zero_fields");
    run_burst(5, 2, 0, -1, "zero_pulses");
    run_burst(4, 3, 5, 8, "abort");
    run_burst(10, 2, 2, -1, "p10");
    run_burst(1, 1, 1, -1, "single");

    // Stop while idle beats a simultaneous start
    bus.num_pulses = NUM_W'(2);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_out("stop_idle", 0, 0, 0, 1);

    // Asynchronous reset in the middle of a high phase
    bus.pulse_len  = CNT_W'(5);
    bus.gap_len    = CNT_W'(5);
    bus.num_pulses = NUM_W'(3);
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_out("pre_rst", 1, 1, 0, 0);
    #3 RESET_N = 1'b0;
    #1 check_out("mid_rst", 0, 0, 0, 0);
    #2 RESET_N = 1'b1;
    tick();
    check_out("after_rst", 0, 0, 0, 0);

    for (int it = 0; it < 25; it++) begin
      p = int'($urandom_range(0, 9));
      g = int'($urandom_range(0, 9));
      n = int'($urandom_range(0, 5));
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 50)) : -1;
      run_burst(p, g, n, s, $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
